// File: rtl/align_pkg.sv
// Shared helpers for the pipelined leading-zero aligner.
package align_pkg;

  // Width of the shift count for a 2**order window: values 0..2**order inclusive.
  function automatic int unsigned align_count_w(int unsigned order);
    return order + 1;
  endfunction

  function automatic int unsigned align_hw(int unsigned order);
    return 1 << order;
  endfunction

  localparam int unsigned AlignOrderDefault = 3;
  localparam int unsigned AlignHwDefault    = align_hw(AlignOrderDefault);
  localparam int unsigned AlignWDefault     = 16;
  localparam int unsigned AlignTwDefault    = 4;

  // Stage payload at the default geometry; done marks an all-zero window.
  typedef struct packed {
    logic [AlignWDefault-1:0]                        data;
    logic [align_count_w(AlignOrderDefault)-1:0]     count;
    logic [AlignTwDefault-1:0]                       tag;
    logic                                            done;
  } align_stage_t;

endpackage

// File: rtl/align_p_if.sv
// Valid/ready stream bundle for align_p: input word side and aligned result side.
interface align_p_if #(
  parameter int unsigned W     = 16,
  parameter int unsigned TW    = 4,
  parameter int unsigned ORDER = 3
);
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_data;
  logic [TW-1:0]    in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     out_data;
  logic [ORDER:0]   out_count;
  logic [TW-1:0]    out_tag;
  logic             out_zero;

  modport master (
    output in_valid, in_data, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_count, out_tag, out_zero
  );

  modport slave (
    input  in_valid, in_data, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_count, out_tag, out_zero
  );
endinterface

// File: rtl/align_p_stage.sv
// One aligner stage: test the top SHIFT bits, shift when clear, and hold one
// word with its own valid bit. FIRST marks the full-window stage.
module align_p_stage import align_pkg::*; #(
  parameter int unsigned W     = 16,
  parameter int unsigned TW    = 4,
  parameter int unsigned ORDER = 3,
  parameter int unsigned SHIFT = 8,
  parameter bit          FIRST = 1'b0
) (
  input  logic                            clock,
  input  logic                            reset_n,
  input  logic                            up_valid,
  input  logic [W-1:0]                    up_data,
  input  logic [align_count_w(ORDER)-1:0] up_count,
  input  logic [TW-1:0]                   up_tag,
  input  logic                            up_done,
  input  logic                            dn_adv,
  output logic                            valid,
  output logic [W-1:0]                    data,
  output logic [align_count_w(ORDER)-1:0] count,
  output logic [TW-1:0]                   tag,
  output logic                            done
);
  localparam int unsigned CW = align_count_w(ORDER);

  logic          adv;
  logic          prior_done;
  logic          hit;
  logic [CW-1:0] prior_count;
  logic [W-1:0]  data_nx;
  logic [CW-1:0] count_nx;
  logic          done_nx;

  // The count bit owned by this stage has weight SHIFT, so setting it is an OR.
  always_comb begin
    prior_done  = FIRST ? 1'b0 : up_done;
    prior_count = FIRST ? '0 : up_count;
    hit         = ~prior_done & ~|up_data[W-1 -: SHIFT];
    data_nx     = hit ? up_data << SHIFT : up_data;
    count_nx    = hit ? (prior_count | CW'(SHIFT)) : prior_count;
    done_nx     = FIRST ? hit : prior_done;
  end

  assign adv = ~valid | dn_adv;

  // Load whenever the slot is free or its word leaves; an empty upstream leaves a bubble.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid <= 1'b0;
      data  <= '0;
      count <= '0;
      tag   <= '0;
      done  <= 1'b0;
    end else if (adv) begin
      valid <= up_valid;
      if (up_valid) begin
        data  <= data_nx;
        count <= count_nx;
        tag   <= up_tag;
        done  <= done_nx;
      end
    end
  end
endmodule

// File: rtl/align_p.sv
// Pipelined leading-zero aligner: out = in << clz(top 2**ORDER bits), saturating.
// Latency ORDER+1, one word per cycle, bubbles collapse under backpressure.
// Optional ALIGN_P_STATS_EN adds stat_clear / stat_zero (zero-window result counter).
module align_p import align_pkg::*; #(
  parameter int unsigned ORDER = 3,
  parameter int unsigned W     = 16,
  parameter int unsigned TW    = 4
) (
  input  logic        clock,
  input  logic        reset_n,
  align_p_if.slave    bus
`ifdef ALIGN_P_STATS_EN
  ,
  input  logic        stat_clear,
  output logic [15:0] stat_zero
`endif
);
  localparam int unsigned HW = align_hw(ORDER);
  localparam int unsigned CW = align_count_w(ORDER);
  localparam int unsigned N  = ORDER + 1;

  if (W < HW) begin : g_bad_width
    $error("align_p: W must be at least 2**ORDER");
  end

  // Index 0 is the input port, index k+1 is the register of stage k.
  logic [N:0]    vin;
  logic [W-1:0]  d [N+1];
  logic [CW-1:0] c [N+1];
  logic [TW-1:0] t [N+1];
  logic          z [N+1];

  assign vin[0] = bus.in_valid;
  assign d[0]   = bus.in_data;
  assign c[0]   = '0;
  assign t[0]   = bus.in_tag;
  assign z[0]   = 1'b0;

  // Stage 0 can take a word unless every stage is full and the sink is stalled.
  assign bus.in_ready = bus.out_ready | ~(&vin[N:1]);

  for (genvar k = 0; k < N; k++) begin : g_stage
    logic dn_adv;
    if (k == N - 1) begin : g_last
      assign dn_adv = bus.out_ready;
    end else begin : g_mid
      // Flattened ready chain: downstream advances unless all later stages are full and stalled.
      assign dn_adv = bus.out_ready | ~(&vin[N:k+2]);
    end

    align_p_stage #(
      .W     (W),
      .TW    (TW),
      .ORDER (ORDER),
      .SHIFT ((k == 0) ? HW : (1 << (ORDER - k))),
      .FIRST (k == 0)
    ) u_stage (
      .clock    (clock),
      .reset_n  (reset_n),
      .up_valid (vin[k]),
      .up_data  (d[k]),
      .up_count (c[k]),
      .up_tag   (t[k]),
      .up_done  (z[k]),
      .dn_adv   (dn_adv),
      .valid    (vin[k+1]),
      .data     (d[k+1]),
      .count    (c[k+1]),
      .tag      (t[k+1]),
      .done     (z[k+1])
    );
  end

  assign bus.out_valid = vin[N];
  assign bus.out_data  = d[N];
  assign bus.out_count = c[N];
  assign bus.out_tag   = t[N];
  assign bus.out_zero  = z[N];

`ifdef ALIGN_P_STATS_EN
  logic [15:0] stat_q;

  // Saturating count of zero-window results handed downstream; clear wins.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stat_q <= '0;
    end else if (stat_clear) begin
      stat_q <= '0;
    end else if (vin[N] & bus.out_ready & z[N] & (stat_q != 16'hFFFF)) begin
      stat_q <= stat_q + 16'd1;
    end
  end

  assign stat_zero = stat_q;
`endif
endmodule

// File: tb/tb_align_p.sv
// Bench for align_p: directed cases plus a random backpressured stream,
// scored against a plain leading-zero model.
module tb_align_p;
  import align_pkg::*;

  localparam int unsigned ORDER = AlignOrderDefault;
  localparam int unsigned W     = AlignWDefault;
  localparam int unsigned TW    = AlignTwDefault;
  localparam int unsigned HW    = 1 << ORDER;
  localparam int          N     = ORDER + 1;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  align_p_if #(.W(W), .TW(TW), .ORDER(ORDER)) bus ();

`ifdef ALIGN_P_STATS_EN
  logic        stat_clear = 1'b0;
  logic [15:0] stat_zero;
  int          stat_model = 0;
`endif

  align_p #(.ORDER(ORDER), .W(W), .TW(TW)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
`ifdef ALIGN_P_STATS_EN
    ,
    .stat_clear (stat_clear),
    .stat_zero  (stat_zero)
`endif
  );

  int           tests = 0;
  int           fails = 0;
  int           cyc = 0;
  int           acc_cyc = 0;
  align_stage_t sb[$];
  align_stage_t cur;
  align_stage_t prev_out;
  bit           hold_prev = 1'b0;

  // Reference: count leading zeros of the top HW bits, then shift.
  function automatic align_stage_t ref_align(logic [W-1:0] din, logic [TW-1:0] tg);
    align_stage_t r;
    int n = 0;
    while (n < int'(HW) && din[W-1-n] == 1'b0) n++;
    r.data  = din << n;
    r.count = n[ORDER:0];
    r.tag   = tg;
    r.done  = (n == int'(HW));
    return r;
  endfunction

  task automatic chk(string name, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  // One clock: score handshakes just before the edge, then land on the next negedge.
  task automatic step(output bit acc);
    bit           outf;
    align_stage_t now_out;
    align_stage_t e;
    #1;
    acc  = bus.in_valid & bus.in_ready;
    outf = bus.out_valid & bus.out_ready;
    now_out = '{data: bus.out_data, count: bus.out_count, tag: bus.out_tag, done: bus.out_zero};
    chk("in_ready", 32'(bus.in_ready), 32'(bus.out_ready | (sb.size() < N)));
    if (hold_prev) begin
      chk("stall_valid", 32'(bus.out_valid), 32'd1);
      chk("stall_hold", 32'(now_out), 32'(prev_out));
    end
    if (outf) begin
      if (sb.size() == 0) begin
        chk("spurious_out", 32'(bus.out_valid), 32'd0);
      end else begin
        e = sb.pop_front();
        chk("out_data", 32'(bus.out_data), 32'(e.data));
        chk("out_count", 32'(bus.out_count), 32'(e.count));
        chk("out_tag", 32'(bus.out_tag), 32'(e.tag));
        chk("out_zero", 32'(bus.out_zero), 32'(e.done));
      end
    end
`ifdef ALIGN_P_STATS_EN
    chk("stat_zero", 32'(stat_zero), 32'(stat_model));
    if (stat_clear) stat_model = 0;
    else if (outf && bus.out_zero && stat_model < 16'hFFFF) stat_model++;
`endif
    hold_prev = bus.out_valid & ~bus.out_ready;
    prev_out  = now_out;
    if (acc) begin
      sb.push_back(cur);
      acc_cyc = cyc;
    end
    @(posedge clock);
    cyc++;
    @(negedge clock);
  endtask

  task automatic send(logic [W-1:0] din, logic [TW-1:0] tg, align_stage_t e);
    bit acc = 1'b0;
    int n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = din;
    bus.in_tag   = tg;
    cur = e;
    while (!acc && n < 200) begin
      step(acc);
      n++;
    end
    if (!acc) chk("send_timeout", 32'(acc), 32'd1);
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    bit acc;
    int n = 0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    while (sb.size() != 0 && n < 200) begin
      step(acc);
      n++;
    end
    if (sb.size() != 0) chk("drain_timeout", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    bit          acc;
    int          i;
    int          n;
    int          stall;
    logic [W-1:0] w;
    logic [TW-1:0] tg;

    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_tag    = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);

    // Reset state.
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_data", 32'(bus.out_data), 32'd0);
    chk("rst_out_count", 32'(bus.out_count), 32'd0);
    chk("rst_out_tag", 32'(bus.out_tag), 32'd0);
    chk("rst_out_zero", 32'(bus.out_zero), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);

    // 0x0123: clz 7, latency ORDER+1.
    bus.out_ready = 1'b1;
    send(16'h0123, 4'h3, '{data: 16'h9180, count: 4'd7, tag: 4'h3, done: 1'b0});
    n = 0;
    while (!bus.out_valid && n < 20) begin
      step(acc);
      n++;
    end
    chk("latency", 32'(cyc - acc_cyc), 32'(N));
    drain();

    // Saturating window cases.
    send(16'h00F0, 4'h5, '{data: 16'hF000, count: 4'd8, tag: 4'h5, done: 1'b1});
    send(16'h0000, 4'h6, '{data: 16'h0000, count: 4'd8, tag: 4'h6, done: 1'b1});
    drain();

    // MSB set and one-below, back to back.
    send(16'h8000, 4'h1, '{data: 16'h8000, count: 4'd0, tag: 4'h1, done: 1'b0});
    send(16'h4000, 4'h2, '{data: 16'h8000, count: 4'd1, tag: 4'h2, done: 1'b0});
    drain();

    // Random stream with random backpressure and one 6-cycle stall.
    i = 0;
    n = 0;
    stall = 0;
    w  = 16'($urandom) >> $urandom_range(0, 16);
    tg = 4'($urandom);
    while (i < 20 && n < 2000) begin
      bus.in_valid  = (stall > 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
      bus.in_data   = w;
      bus.in_tag    = tg;
      cur           = ref_align(w, tg);
      bus.out_ready = (stall > 0) ? 1'b0 : 1'($urandom_range(0, 1));
      if (stall > 0) stall--;
      step(acc);
      n++;
      if (acc) begin
        i++;
        if (i == 8) stall = 6;
        w  = 16'($urandom) >> $urandom_range(0, 16);
        tg = 4'($urandom);
      end
    end
    if (i < 20) chk("stream_timeout", 32'(i), 32'd20);
    drain();

    // Reset with three words in flight.
    bus.out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      w = 16'($urandom);
      send(w, 4'(k), ref_align(w, 4'(k)));
    end
    #2 reset_n = 1'b0;
    #1 chk("rst_mid_out_valid", 32'(bus.out_valid), 32'd0);
    sb.delete();
    hold_prev = 1'b0;
`ifdef ALIGN_P_STATS_EN
    stat_model = 0;
`endif
    @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      chk("post_rst_idle", 32'(bus.out_valid), 32'd0);
      step(acc);
    end
    send(16'h0F00, 4'hA, '{data: 16'hF000, count: 4'd4, tag: 4'hA, done: 1'b0});
    drain();

`ifdef ALIGN_P_STATS_EN
    stat_clear = 1'b1;
    step(acc);
    stat_clear = 1'b0;
    for (int k = 0; k < 5; k++) begin
      send(16'h00AB, 4'(k), '{data: 16'hAB00, count: 4'd8, tag: 4'(k), done: 1'b1});
    end
    drain();
    step(acc);
    chk("stat_five", 32'(stat_zero), 32'd5);
    bus.out_ready = 1'b0;
    send(16'h0000, 4'h7, '{data: 16'h0000, count: 4'd8, tag: 4'h7, done: 1'b1});
    n = 0;
    while (!bus.out_valid && n < 20) begin
      step(acc);
      n++;
    end
    stat_clear = 1'b1;
    bus.out_ready = 1'b1;
    step(acc);
    stat_clear = 1'b0;
    step(acc);
    chk("stat_clear_wins", 32'(stat_zero), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
